// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port integer register file.
// The decode and writeback stages import the same defaults.
package regfile_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_NRD   = 2;

    typedef enum logic {
        RF_INIT,
        RF_RUN
    } rf_state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between the pipeline (decode reads / scoreboard set, writeback writes) and the register file.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = RF_XLEN,
    parameter int NREGS = RF_NREGS,
    parameter int NRD   = RF_NRD
);
    localparam int AW = $clog2(NREGS);

    logic                clr_req;
    logic                ready;
    logic                we;
    logic [AW-1:0]       waddr;
    logic [XLEN-1:0]     wdata;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;

    modport master (
        output clr_req, we, waddr, wdata, rd_addr, sb_set, sb_addr,
        input  ready, rd_data, rd_busy
    );

    modport slave (
        input  clr_req, we, waddr, wdata, rd_addr, sb_set, sb_addr,
        output ready, rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write bit per register with NRD lookup ports; a same-cycle set beats a clear.
// Bit 0 never leaves zero because the x0 register can have no producer.
module regfile_scoreboard #(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] lk_addr,
    output logic [NRD-1:0]    lk_busy
);

    logic [NREGS-1:0] pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (clr) begin
            pending <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (set_en && set_addr == AW'(i)) begin
                    pending[i] <= 1'b1;
                end else if (clr_en && clr_addr == AW'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_lk
        assign lk_busy[p] = pending[lk_addr[p*AW +: AW]];
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with optional write-to-read bypass, hardwired x0,
// pending-write scoreboard and a sequencer that zeroes every entry after reset or clr_req.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int NRD    = RF_NRD,
    parameter bit BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] CNT_FIRST = (AW+1)'(1);
    localparam logic [AW:0] CNT_LAST  = (AW+1)'(NREGS - 1);

    rf_state_e       state;
    logic [AW:0]     cnt;
    logic [XLEN-1:0] mem [NREGS];
    logic            run;
    logic            sb_clr;
    logic            sb_set_en;
    logic            sb_clr_en;
    logic [NRD-1:0]  sb_busy;

    assign run       = (state == RF_RUN);
    assign bus.ready = run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RF_INIT;
            cnt   <= CNT_FIRST;
        end else begin
            case (state)
                RF_INIT: begin
                    if (bus.clr_req) begin
                        cnt <= CNT_FIRST;
                    end else if (cnt == CNT_LAST) begin
                        state <= RF_RUN;
                        cnt   <= CNT_FIRST;
                    end else begin
                        cnt <= cnt + CNT_FIRST;
                    end
                end
                RF_RUN: begin
                    if (bus.clr_req) begin
                        state <= RF_INIT;
                        cnt   <= CNT_FIRST;
                    end
                end
                default: begin
                    state <= RF_INIT;
                    cnt   <= CNT_FIRST;
                end
            endcase
        end
    end

    // Entry 0 is never written; reads of x0 are forced to zero instead.
    always_ff @(posedge clk) begin
        if (!run) begin
            mem[cnt[AW-1:0]] <= '0;
        end else if (bus.we && !bus.clr_req && bus.waddr != '0) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    assign sb_clr    = !run || bus.clr_req;
    assign sb_set_en = run && bus.sb_set;
    assign sb_clr_en = run && bus.we;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sb_clr),
        .set_en   (sb_set_en),
        .set_addr (bus.sb_addr),
        .clr_en   (sb_clr_en),
        .clr_addr (bus.waddr),
        .lk_addr  (bus.rd_addr),
        .lk_busy  (sb_busy)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic            set_here;
        logic [XLEN-1:0] data;

        assign addr     = bus.rd_addr[p*AW +: AW];
        assign hit      = BYPASS && run && bus.we && (bus.waddr == addr);
        assign set_here = bus.sb_set && (bus.sb_addr == addr);

        always_comb begin
            data = '0;
            if (run && addr != '0) begin
                data = hit ? bus.wdata : mem[addr];
            end
        end

        assign bus.rd_data[p*XLEN +: XLEN] = data;
        // A forwarded write retires the producer this cycle unless a new one issues alongside it.
        assign bus.rd_busy[p] = run && sb_busy[p] && !(hit && !set_here);
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance see identical stimulus.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int XLEN  = RF_XLEN;
    localparam int NREGS = RF_NREGS;
    localparam int NRD   = RF_NRD;
    localparam int AW    = $clog2(NREGS);

    typedef enum int {K_READY, K_DATA_B, K_DATA_N, K_BUSY_B, K_BUSY_N} kind_e;

    typedef struct {
        string       tag;
        kind_e       kind;
        int          port;
        logic [31:0] exp_val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            clr_req = 1'b0;
    logic            we      = 1'b0;
    logic            sb_set  = 1'b0;
    logic [AW-1:0]   waddr   = '0;
    logic [AW-1:0]   sb_addr = '0;
    logic [AW-1:0]   ra0     = '0;
    logic [AW-1:0]   ra1     = '0;
    logic [XLEN-1:0] wdata   = '0;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_b ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus_n ();

    assign bus_b.clr_req = clr_req;
    assign bus_b.we      = we;
    assign bus_b.waddr   = waddr;
    assign bus_b.wdata   = wdata;
    assign bus_b.rd_addr = {ra1, ra0};
    assign bus_b.sb_set  = sb_set;
    assign bus_b.sb_addr = sb_addr;

    assign bus_n.clr_req = clr_req;
    assign bus_n.we      = we;
    assign bus_n.waddr   = waddr;
    assign bus_n.wdata   = wdata;
    assign bus_n.rd_addr = {ra1, ra0};
    assign bus_n.sb_set  = sb_set;
    assign bus_n.sb_addr = sb_addr;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1'b0)) dut_n (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_n)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] observe(kind_e k, int port);
        case (k)
            K_READY:  return {30'd0, bus_b.ready, bus_n.ready};
            K_DATA_B: return bus_b.rd_data[port*XLEN +: XLEN];
            K_DATA_N: return bus_n.rd_data[port*XLEN +: XLEN];
            K_BUSY_B: return {31'd0, bus_b.rd_busy[port]};
            K_BUSY_N: return {31'd0, bus_n.rd_busy[port]};
            default:  return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic push_exp(input string tag, input kind_e k, input int port, input logic [31:0] v);
        exp_t e;
        e.tag     = tag;
        e.kind    = k;
        e.port    = port;
        e.exp_val = v;
        exp_q.push_back(e);
    endtask

    task automatic exp_data(input string tag, input int port, input logic [31:0] vb, input logic [31:0] vn);
        push_exp({tag, "/byp"}, K_DATA_B, port, vb);
        push_exp({tag, "/nob"}, K_DATA_N, port, vn);
    endtask

    task automatic exp_busy(input string tag, input int port, input logic vb, input logic vn);
        push_exp({tag, "/byp"}, K_BUSY_B, port, {31'd0, vb});
        push_exp({tag, "/nob"}, K_BUSY_N, port, {31'd0, vn});
    endtask

    task automatic exp_ready(input string tag, input logic v);
        push_exp(tag, K_READY, 0, v ? 32'd3 : 32'd0);
    endtask

    task automatic applyStimulus(input logic w, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic s, input logic [AW-1:0] sa, input logic c);
        we      = w;
        waddr   = wa;
        wdata   = wd;
        ra0     = a0;
        ra1     = a1;
        sb_set  = s;
        sb_addr = sa;
        clr_req = c;
    endtask

    task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        applyStimulus(1'b0, '0, '0, a0, a1, 1'b0, '0, 1'b0);
    endtask

    // Compare everything queued for this cycle at the falling edge, then move past the next rising edge.
    task automatic end_cycle();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observe(e.kind, e.port), e.exp_val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int want_cycles);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus_b.ready && bus_n.ready) break;
            n++;
        end
        checkOutput(tag, n, want_cycles);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");

        // Held in reset: outputs forced quiet
        idle(5'd3, 5'd9);
        exp_ready("rst_ready", 1'b0);
        exp_data("rst_data", 0, 32'd0, 32'd0);
        exp_busy("rst_busy", 1, 1'b0, 1'b0);
        end_cycle();

        // 1: initial zeroing takes 31 cycles, then every register reads 0
        rst_n = 1'b1;
        wait_ready("init_len", 31);
        for (int a = 0; a < NREGS; a += 2) begin
            idle(AW'(a), AW'(a + 1));
            exp_ready("sweep_ready", 1'b1);
            exp_data($sformatf("sweep_x%0d", a), 0, 32'd0, 32'd0);
            exp_data($sformatf("sweep_x%0d", a + 1), 1, 32'd0, 32'd0);
            exp_busy($sformatf("sweep_busy_x%0d", a), 0, 1'b0, 1'b0);
            exp_busy($sformatf("sweep_busy_x%0d", a + 1), 1, 1'b0, 1'b0);
            end_cycle();
        end

        // 2: same-cycle write to x5 seen only by the bypassing file
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, '0, 1'b0);
        exp_data("byp_p0", 0, 32'hDEAD_BEEF, 32'd0);
        exp_data("byp_p1", 1, 32'hDEAD_BEEF, 32'd0);
        end_cycle();
        idle(5'd5, 5'd5);
        exp_data("wr_p0", 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        exp_data("wr_p1", 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        end_cycle();

        // 3: x0 stays zero even when written and bypass would match
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0, 1'b0, '0, 1'b0);
        exp_data("x0_same", 0, 32'd0, 32'd0);
        exp_data("x0_same", 1, 32'd0, 32'd0);
        end_cycle();
        idle(5'd0, 5'd0);
        exp_data("x0_after", 0, 32'd0, 32'd0);
        end_cycle();

        // 4: scoreboard set / clear / set-wins on x7
        applyStimulus(1'b0, '0, '0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
        exp_busy("sb_set_same", 0, 1'b0, 1'b0);
        end_cycle();
        idle(5'd7, 5'd0);
        exp_busy("sb_busy7", 0, 1'b1, 1'b1);
        exp_busy("sb_busy0", 1, 1'b0, 1'b0);
        end_cycle();
        applyStimulus(1'b1, 5'd7, 32'h0000_0077, 5'd7, 5'd7, 1'b0, '0, 1'b0);
        exp_busy("sb_wr_mask", 0, 1'b0, 1'b1);
        exp_data("sb_wr_data", 0, 32'h0000_0077, 32'd0);
        end_cycle();
        idle(5'd7, 5'd7);
        exp_busy("sb_cleared", 0, 1'b0, 1'b0);
        exp_data("x7_data", 0, 32'h0000_0077, 32'h0000_0077);
        end_cycle();
        applyStimulus(1'b0, '0, '0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
        end_cycle();
        applyStimulus(1'b1, 5'd7, 32'h0000_0099, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0);
        exp_busy("set_wins_same", 0, 1'b1, 1'b1);
        exp_data("set_wins_data", 0, 32'h0000_0099, 32'h0000_0077);
        end_cycle();
        idle(5'd7, 5'd7);
        exp_busy("set_wins_next", 1, 1'b1, 1'b1);
        exp_data("x7_data2", 1, 32'h0000_0099, 32'h0000_0099);
        end_cycle();

        // 5: clr_req re-zeroes the file and drops pending bits
        applyStimulus(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd3, 5'd7, 1'b0, '0, 1'b0);
        exp_data("x3_byp", 0, 32'hA5A5_A5A5, 32'd0);
        end_cycle();
        applyStimulus(1'b1, 5'd3, 32'h0000_0011, 5'd3, 5'd7, 1'b0, '0, 1'b1);
        exp_ready("clr_cycle_ready", 1'b1);
        exp_data("clr_cycle_x3", 0, 32'h0000_0011, 32'hA5A5_A5A5);
        exp_busy("clr_cycle_x7", 1, 1'b1, 1'b1);
        end_cycle();
        applyStimulus(1'b1, 5'd3, 32'hFFFF_FFFF, 5'd3, 5'd3, 1'b1, 5'd3, 1'b0);
        exp_ready("clr_init_ready", 1'b0);
        exp_data("clr_init_data", 0, 32'd0, 32'd0);
        exp_busy("clr_init_busy", 1, 1'b0, 1'b0);
        end_cycle();
        idle(5'd3, 5'd7);
        wait_ready("clr_len", 30);
        idle(5'd3, 5'd7);
        exp_data("x3_zeroed", 0, 32'd0, 32'd0);
        exp_busy("x3_busy", 0, 1'b0, 1'b0);
        exp_busy("x7_busy_cleared", 1, 1'b0, 1'b0);
        end_cycle();

        // 6: async reset while busy, then again mid-initialisation
        applyStimulus(1'b0, '0, '0, 5'd9, 5'd9, 1'b1, 5'd9, 1'b0);
        end_cycle();
        idle(5'd9, 5'd9);
        exp_busy("x9_busy", 0, 1'b1, 1'b1);
        end_cycle();
        rst_n = 1'b0;
        exp_ready("arst_ready", 1'b0);
        exp_busy("arst_busy0", 0, 1'b0, 1'b0);
        exp_busy("arst_busy1", 1, 1'b0, 1'b0);
        end_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_ready("mid_init_ready", 1'b0);
            end_cycle();
        end
        rst_n = 1'b0;
        exp_ready("mid_init_rst", 1'b0);
        end_cycle();
        rst_n = 1'b1;
        wait_ready("reinit_len", 31);
        idle(5'd9, 5'd5);
        exp_ready("final_ready", 1'b1);
        exp_busy("x9_after_rst", 0, 1'b0, 1'b0);
        exp_data("x5_after_rst", 1, 32'd0, 32'd0);
        end_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file with a write-before-read bypass, hardwired zero register, per-register pending-write scoreboard and a zero-initialisation sequencer. Replaces the fixed 2R1W file in the decode/writeback stages of the 3-stage pipeline. Writeback drives the write port; decode drives the read ports and the scoreboard-set port.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored value
AW, $clog2(NREGS), address width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
clr_req  input  1  pulse: re-run zero-initialisation of all registers
ready  output  1  1 = file is initialised and accepts reads/writes
we  input  1  write enable
waddr  input  AW  write address
wdata  input  XLEN  write data
rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  output  NRD  1 = register addressed by port i has an outstanding producer
sb_set  input  1  mark sb_addr as pending (issue of a long-latency producer)
sb_addr  input  AW  scoreboard address

Behaviour:
- Storage: NREGS x XLEN array, no reset on the array itself; contents are defined only via the init sequencer.
- Reset (rst_n low, async): FSM -> INIT, init counter = 1, all scoreboard bits = 0, ready = 0. rd_data = 0 and rd_busy = 0 while ready = 0.
- FSM states: INIT, RUN.
  - INIT: each cycle write 0 to entry[cnt], cnt++; after writing entry NREGS-1 -> RUN next cycle. Takes NREGS-1 cycles; ready rises on the first cycle in RUN. we/sb_set ignored in INIT.
  - RUN: ready = 1. clr_req=1 -> INIT (cnt=1), scoreboard cleared, write in the same cycle discarded.
  - clr_req during INIT restarts the count at 1.
- Write: in RUN, we=1 and waddr!=0 -> entry[waddr] <= wdata at rising edge. waddr=0 is ignored.
- Read (combinational): rd_addr=0 -> 0. Else if BYPASS=1, we=1, waddr==rd_addr, RUN -> wdata. Else entry[rd_addr]. All NRD ports are independent; any number may alias the same address.
- Scoreboard: NREGS bits, bit 0 is constant 0.
  - we=1 in RUN clears bit[waddr] at the edge.
  - sb_set=1 in RUN sets bit[sb_addr] (sb_addr=0 ignored).
  - sb_set and we on the same address in the same cycle: set wins (bit = 1).
- rd_busy[i] = bit[rd_addr[i]]. With BYPASS=1, the bit is masked to 0 when the same-cycle write matches and is not overridden by a same-cycle sb_set to that address.
- Widths: no arithmetic beyond the counter. The counter is AW+1 bits so the terminal compare does not wrap.

Decomposition:
- Package regfile_pkg: FSM state enum rf_state_e {RF_INIT, RF_RUN}, and the default XLEN/NREGS constants shared with the decode and writeback stages.
- One sub-module, regfile_scoreboard: NREGS-bit set/clear vector with NRD lookup ports and the set-wins priority. The top level keeps the storage, bypass muxes and FSM.

Test Plan:
1. Release rst_n, hold all inputs 0 -> ready=0 for 31 cycles, then 1. Reads of all 32 addresses = 0, rd_busy all 0.
2. RUN: we=1, waddr=5, wdata=0xDEADBEEF with rd_addr port0=5, port1=5, BYPASS=1 -> both ports read 0xDEADBEEF in the same cycle and next cycle. With BYPASS=0 -> old value 0 this cycle, 0xDEADBEEF next.
3. we=1, waddr=0, wdata=0x1234 -> reading address 0 returns 0 in the same cycle and afterwards.
4. sb_set addr 7 -> next cycle rd_busy for a port reading 7 = 1. Write 7 -> busy 0 the following cycle. Then sb_set=1 and we=1 to address 7 together -> busy stays 1.
5. Write x3=0xA5A5A5A5, then pulse clr_req -> ready=0 next cycle for 31 cycles, write attempt during INIT ignored, x3 reads 0 after ready returns.
6. Assert rst_n low mid-INIT (cycle 10) and after sb_set on x9 -> ready drops immediately, rd_busy=0. Full 31-cycle init repeats after release.
